// File: rtl/key_debouncer_pkg.sv
// Shared constants and types for the push-button debouncer.
// Holds the project clock/debounce-window constants from which the default
// stability count is derived, plus the accepted-level type used by each channel.
package key_debouncer_pkg;

    // Project timing constants: 50 MHz system clock, 2.5 ms debounce window.
    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned DEBOUNCE_US = 2_500;

    // Stable cycles spanning a window; clk_hz is scaled first to stay within 32 bits.
    function automatic int unsigned debounce_counts(input int unsigned clk_hz,
                                                    input int unsigned window_us);
        return ((clk_hz / 32'd1000) * window_us) / 32'd1000;
    endfunction

    localparam int unsigned DEFAULT_NUM_KEYS     = 3;
    localparam int unsigned DEFAULT_DELAY_COUNTS = debounce_counts(CLK_HZ, DEBOUNCE_US);

    // Raw DE-series keys idle high; synchronizer flops reset to this level.
    localparam logic RAW_RELEASED = 1'b1;

    // Accepted (debounced) level of one key, active-high.
    typedef enum logic {
        KEY_UP   = 1'b0,
        KEY_DOWN = 1'b1
    } key_state_e;

endpackage

// File: rtl/key_debouncer_channel.sv
// One debounce channel: 2-flop synchronizer, stability counter, accepted level
// and one-cycle press/release pulses.
// Ports:
//   clk            - system clock
//   reset          - synchronous active-high reset
//   key_raw        - raw pin, active-low, asynchronous to clk
//   key_debounced  - accepted level, active-high (registered)
//   pressed_pulse  - one cycle high when the accepted level goes 0->1 (registered)
//   released_pulse - one cycle high when the accepted level goes 1->0 (registered)
module debounce_channel
    import key_debouncer_pkg::*;
#(
    parameter int unsigned DELAY_COUNTS = DEFAULT_DELAY_COUNTS
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_debounced,
    output logic pressed_pulse,
    output logic released_pulse
);

    localparam int unsigned        CNT_W    = $clog2(DELAY_COUNTS + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DELAY_COUNTS - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    key_state_e       state_q, state_d;
    logic             pressed_q, pressed_d;
    logic             released_q, released_d;
    key_state_e       level_in_c;

    // State register; reset also discards any partial count and pending pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= RAW_RELEASED;
            sync2_q    <= RAW_RELEASED;
            cnt_q      <= '0;
            state_q    <= KEY_UP;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    // Next-state: count consecutive samples disagreeing with the accepted level.
    always_comb begin
        sync1_d    = key_raw;
        sync2_d    = sync1_q;
        cnt_d      = '0;
        state_d    = state_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        level_in_c = sync2_q ? KEY_UP : KEY_DOWN;

        if (level_in_c == state_q) begin
            // Any agreeing sample restarts the stability window.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Mismatch has now been seen DELAY_COUNTS times in a row.
            state_d    = level_in_c;
            pressed_d  = (level_in_c == KEY_DOWN);
            released_d = (level_in_c == KEY_UP);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign key_debounced  = (state_q == KEY_DOWN);
    assign pressed_pulse  = pressed_q;
    assign released_pulse = released_q;

endmodule

// File: rtl/key_debouncer.sv
// Debouncer for the DE-series push-buttons KEY0..KEY(NUM_KEYS-1).
// Each key gets an independent debounce_channel in the single clk domain.
// Ports:
//   clk                - system clock
//   reset              - synchronous active-high reset
//   KEY_raw            - raw pins, active-low, bit i = KEYi
//   KEY_debounced      - debounced levels, active-high (feed KEY0..2_debounced)
//   KEY_pressed_pulse  - one-cycle pulse per accepted press
//   KEY_released_pulse - one-cycle pulse per accepted release
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = DEFAULT_NUM_KEYS,
    parameter int unsigned DELAY_COUNTS = DEFAULT_DELAY_COUNTS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY_raw,
    output logic [NUM_KEYS-1:0] KEY_debounced,
    output logic [NUM_KEYS-1:0] KEY_pressed_pulse,
    output logic [NUM_KEYS-1:0] KEY_released_pulse
);

    // One fully independent channel per key.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        debounce_channel #(
            .DELAY_COUNTS (DELAY_COUNTS)
        ) u_chan (
            .clk            (clk),
            .reset          (reset),
            .key_raw        (KEY_raw[i]),
            .key_debounced  (KEY_debounced[i]),
            .pressed_pulse  (KEY_pressed_pulse[i]),
            .released_pulse (KEY_released_pulse[i])
        );
    end

endmodule
